// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the single-cell BIST sequencer.
// Contents: FSM state enum, input/settle limits, reference truth tables
// for the common 4-input cells (bit v = expected Y for input vector v).
package cell_bist_pkg;

  localparam int unsigned MAX_INPUTS = 4;
  localparam int unsigned MAX_SETTLE = 15;
  localparam int unsigned SETTLE_W   = $clog2(MAX_SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  localparam logic [15:0] TT_NOR4  = 16'h0001;
  localparam logic [15:0] TT_NAND4 = 16'h7FFF;
  localparam logic [15:0] TT_AND4  = 16'h8000;
  localparam logic [15:0] TT_OR4   = 16'hFFFE;

endpackage

// File: rtl/cell_bist_settle_timer.sv
// Loadable down-counter that times the APPLY phase.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       load load_val_i (wins over en_i)
//   en_i         decrement by one, saturating at zero
//   load_val_i   value to load
//   tc_o         registered terminal count: counter is zero
module cell_bist_settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // tc is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/cell_bist_sequencer.sv
// BIST controller for one combinational library cell: sweeps every input
// vector into the CUT, holds each for SETTLE_CYCLES, samples Y once and
// compares it against a truth table captured at start.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         begin a run (honoured only in IDLE)
//   truth_table_i   expected Y; bit v is the output for input vector v
//   dut_in_o        CUT inputs, bit 0 -> A1
//   dut_out_i       CUT output Y
//   busy_o          run in progress
//   done_o          one-cycle pulse at end of run
//   pass_o          result of last completed run
//   fail_count_o    mismatching vectors in the last/current run
//   fail_vec_o      first mismatching vector (valid when pass_o=0 after done)
// Build option: define CELL_BIST_STOP_ON_FAIL_EN to end the run at the
// first mismatching vector.
module cell_bist_sequencer
  import cell_bist_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [(1<<N_INPUTS)-1:0] truth_table_i,
  output logic [N_INPUTS-1:0]      dut_in_o,
  input  logic                     dut_out_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [N_INPUTS:0]        fail_count_o,
  output logic [N_INPUTS-1:0]      fail_vec_o
);

  localparam int unsigned NV    = 1 << N_INPUTS;
  localparam int unsigned CNT_W = N_INPUTS + 1;

  bist_state_e          state_q, state_d;
  logic [N_INPUTS-1:0]  dut_in_q, dut_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     fail_count_q, fail_count_d;
  logic [N_INPUTS-1:0]  fail_vec_q, fail_vec_d;
  logic [NV-1:0]        table_q, table_d;

  logic                 timer_load, timer_en, settle_tc;
  logic                 mismatch, last_vec, stop_hit, sample_end;

  cell_bist_settle_timer #(
    .WIDTH(SETTLE_W)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timer_load),
    .en_i      (timer_en),
    .load_val_i(SETTLE_W'(SETTLE_CYCLES - 1)),
    .tc_o      (settle_tc)
  );

  assign mismatch = (dut_out_i != table_q[dut_in_q]);
  assign last_vec = (dut_in_q == '1);

`ifdef CELL_BIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  assign sample_end = last_vec || stop_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = APPLY;
      APPLY:   if (settle_tc) state_d = SAMPLE;
      SAMPLE:  state_d = sample_end ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; all outputs leave through registers.
  always_comb begin
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_vec_d   = fail_vec_q;
    table_d      = table_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          table_d      = truth_table_i;
          dut_in_d     = '0;
          fail_count_d = '0;
          fail_vec_d   = '0;
          busy_d       = 1'b1;
          timer_load   = 1'b1;
        end
      end
      APPLY: begin
        timer_en = 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (fail_count_q == '0) fail_vec_d = dut_in_q;
          fail_count_d = fail_count_q + CNT_W'(1);
        end
        if (sample_end) begin
          // Registered so done/pass/busy change together on entry to DONE.
          done_d   = 1'b1;
          busy_d   = 1'b0;
          dut_in_d = '0;
          pass_d   = (fail_count_d == '0);
        end else begin
          dut_in_d   = dut_in_q + N_INPUTS'(1);
          timer_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      fail_vec_q   <= '0;
      table_q      <= '0;
    end else begin
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_vec_q   <= fail_vec_d;
      table_q      <= table_d;
    end
  end

  assign dut_in_o     = dut_in_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_count_o = fail_count_q;
  assign fail_vec_o   = fail_vec_q;

endmodule

// File: tb/tb_cell_bist_sequencer.sv
// Scoreboard bench for cell_bist_sequencer: two instances (4-input/settle 2
// and 2-input/settle 1) driven by a behavioural CUT lookup with glitches
// injected during the hold phase.
module tb_cell_bist_sequencer;
  import cell_bist_pkg::*;

  localparam int N0 = 4;
  localparam int S0 = 2;
  localparam int N1 = 2;
  localparam int S1 = 1;

  typedef struct {
    bit pass;
    int fcount;
    int fvec;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_v [2];
  logic [15:0] tt_v    [2];
  logic [15:0] func_v  [2];
  logic        dout_v  [2];
  logic [3:0]  din_v   [2];
  logic [4:0]  fc_v    [2];
  logic [3:0]  fv_v    [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        pass_v  [2];

  logic [3:0] din0, fv0;
  logic [4:0] fc0;
  logic [1:0] din1, fv1;
  logic [2:0] fc1;
  logic       busy0, done0, pass0, busy1, done1, pass1;

  cell_bist_sequencer #(.N_INPUTS(N0), .SETTLE_CYCLES(S0)) u0 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_v[0]),
    .truth_table_i(tt_v[0]),
    .dut_in_o     (din0),
    .dut_out_i    (dout_v[0]),
    .busy_o       (busy0),
    .done_o       (done0),
    .pass_o       (pass0),
    .fail_count_o (fc0),
    .fail_vec_o   (fv0)
  );

  cell_bist_sequencer #(.N_INPUTS(N1), .SETTLE_CYCLES(S1)) u1 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_v[1]),
    .truth_table_i(tt_v[1][3:0]),
    .dut_in_o     (din1),
    .dut_out_i    (dout_v[1]),
    .busy_o       (busy1),
    .done_o       (done1),
    .pass_o       (pass1),
    .fail_count_o (fc1),
    .fail_vec_o   (fv1)
  );

  assign din_v[0]  = din0;
  assign din_v[1]  = {2'b00, din1};
  assign fc_v[0]   = fc0;
  assign fc_v[1]   = {2'b00, fc1};
  assign fv_v[0]   = fv0;
  assign fv_v[1]   = {2'b00, fv1};
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign pass_v[0] = pass0;
  assign pass_v[1] = pass1;

  // Scoreboard state: driver pushes / bumps issued, monitor pops / bumps completed.
  exp_t exp_q   [2][$];
  int   issued    [2] = '{0, 0};
  int   completed [2] = '{0, 0};
  int   a_cyc     [2] = '{0, 0};
  int   lat_exp   [2] = '{0, 0};

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: walk every vector, count disagreements between cell and table.
  function automatic exp_t ref_model(input logic [15:0] tt, input logic [15:0] func,
                                     input int n, input int s);
    exp_t e;
    int nv;
    nv       = 1 << n;
    e.fcount = 0;
    e.fvec   = 0;
    e.lat    = nv * (s + 1);
    for (int v = 0; v < nv; v++) begin
      if (func[v] != tt[v]) begin
        if (e.fcount == 0) e.fvec = v;
        e.fcount++;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        e.lat = (v + 1) * (s + 1);
        break;
`endif
      end
    end
    e.pass = (e.fcount == 0);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Behavioural CUT: table lookup, random glitches only while the vector is settling.
  always @(posedge clk) begin
    int k, ss;
    bit g;
    #1;
    for (int i = 0; i < 2; i++) begin
      ss = (i == 0) ? S0 : S1;
      g  = 1'b0;
      if (issued[i] != completed[i]) begin
        k = cyc - a_cyc[i];
        if ((k % (ss + 1)) < ss) g = 1'($urandom_range(0, 1));
      end
      dout_v[i] = func_v[i][din_v[i]] ^ g;
    end
  end

  // Monitor: sweep/hold checks during a run, scoreboard pop on done.
  always @(negedge clk) begin
    int k, ss;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      ss = (i == 0) ? S0 : S1;
      if (rst) begin
        chk("rst busy", busy_v[i], 0);
        chk("rst done", done_v[i], 0);
        chk("rst pass", pass_v[i], 0);
        chk("rst dut_in", din_v[i], 0);
        chk("rst fail_count", fc_v[i], 0);
        chk("rst fail_vec", fv_v[i], 0);
      end else if (issued[i] != completed[i]) begin
        k = cyc - a_cyc[i];
        if (k < lat_exp[i]) begin
          chk("dut_in sweep", din_v[i], k / (ss + 1));
          chk("busy in run", busy_v[i], 1);
          chk("done early", done_v[i], 0);
        end else begin
          chk("done at latency", done_v[i], 1);
          chk("scoreboard depth", exp_q[i].size(), 1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk("pass", pass_v[i], int'(e.pass));
            chk("fail_count", fc_v[i], e.fcount);
            if (!e.pass) chk("fail_vec", fv_v[i], e.fvec);
            chk("dut_in at done", din_v[i], 0);
            chk("busy at done", busy_v[i], 0);
          end
          completed[i]++;
        end
      end else begin
        chk("stray done", done_v[i], 0);
      end
    end
  end

  task automatic run(input int i, input logic [15:0] tt, input logic [15:0] func,
                     input bit noise);
    exp_t e;
    int b;
    e = ref_model(tt, func, (i == 0) ? N0 : N1, (i == 0) ? S0 : S1);
    @(negedge clk);
    func_v[i]  = func;
    tt_v[i]    = tt;
    start_v[i] = 1'b1;
    exp_q[i].push_back(e);
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    a_cyc[i]   = cyc;
    lat_exp[i] = e.lat;
    issued[i]++;
    for (int k = 0; k <= e.lat + 1; k++) begin
      @(negedge clk);
      start_v[i] = noise && (k == 5 || k == e.lat - 1 || k == e.lat);
      if (noise && k == 10) tt_v[i] = '0;
    end
    start_v[i] = 1'b0;
    b = 0;
    while (issued[i] != completed[i]) begin
      @(negedge clk);
      b++;
      if (b > 200) begin
        $display("FAIL run timeout inst %0d: done never observed", i);
        $fatal(1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] tt, f;
    int inst;
    start_v = '{1'b0, 1'b0};
    tt_v    = '{16'h0, 16'h0};
    func_v  = '{16'h0, 16'h0};
    dout_v  = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run(0, TT_NOR4, TT_NOR4, 1'b0);   // good NOR4
    run(0, TT_NOR4, 16'h0000, 1'b0);  // stuck-at-0
    run(0, TT_NOR4, 16'hFFFF, 1'b0);  // stuck-at-1
    run(0, TT_NOR4, TT_NOR4, 1'b1);   // ignored starts, table change mid-run

    // Reset in the middle of a failing run: outputs clear before the next edge.
    @(negedge clk);
    func_v[0]  = 16'hFFFF;
    tt_v[0]    = TT_NOR4;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(0, TT_NOR4, TT_NOR4, 1'b0);

    run(1, 16'h0007, 16'h0007, 1'b0); // NAND2, settle 1
    run(1, 16'h0007, 16'h000F, 1'b0);

    for (int r = 0; r < 10; r++) begin
      inst = int'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       tt = TT_NOR4;
        1:       tt = TT_NAND4;
        2:       tt = TT_AND4;
        3:       tt = TT_OR4;
        default: tt = 16'($urandom);
      endcase
      f = tt ^ 16'($urandom & $urandom & $urandom);
      if (inst == 1) begin
        tt = tt & 16'h000F;
        f  = f & 16'h000F;
      end
      run(inst, tt, f, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
